// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and stall control for a five-stage in-order pipeline. It combines
//   three hazard sources into the pipeline-register enables:
//     * data-memory wait (freeze of the whole pipe while dmem is busy),
//     * taken branch resolved in EX (squash IF/ID, bubble into EX),
//     * load-use dependency between the load in EX and the instruction in ID.
//   Priority: freeze > branch_taken > load-use > normal.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   id_rs1/id_rs2       source registers of the instruction in ID
//   id_use1/id_use2     the ID instruction actually reads rs1 / rs2
//   ex_dest             destination register of the instruction in ID/EX
//   ex_rmem/ex_wreg     ID/EX holds a load / writes a register
//   mem_rmem/mem_wmem   EX/MEM holds a load / store
//   branch_taken        taken branch resolved in EX
//   dmem_ack            data memory completes the current access
//   en_if..en_mem       pipeline register enables (1 = advance)
//   bubble_ex           load a NOP into ID/EX
//   flush_id            clear IF/ID
//   dmem_req            data memory request
//   mem_err             sticky memory timeout error
//   stall_cnt           saturating count of stall cycles
//   dbg_state           current controller state (0 RUN, 1 WAIT, 2 ERR)
//
// Memory handshake: dmem_req is held high for as long as the access in
// EX/MEM is outstanding; the access completes in the cycle where
// dmem_req and dmem_ack are both high. A dmem_ack seen while dmem_req is
// low carries no meaning and is ignored.

module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       id_rs1,
   input  logic [3:0]       id_rs2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic [3:0]       ex_dest,
   input  logic             ex_rmem,
   input  logic             ex_wreg,
   input  logic             mem_rmem,
   input  logic             mem_wmem,
   input  logic             branch_taken,
   input  logic             dmem_ack,
   output logic             en_if,
   output logic             en_id,
   output logic             en_ex,
   output logic             en_mem,
   output logic             bubble_ex,
   output logic             flush_id,
   output logic             dmem_req,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       dbg_state
);

   localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t            state;
   logic [WCNT_W-1:0] wait_cnt;

   logic mem_op;
   logic lu;
   logic freeze;
   logic lu_stall;
   logic stall_evt;

   assign mem_op = mem_rmem | mem_wmem;

   // Every register index, including 0, is treated as a real dependency.
   assign lu = ex_rmem & ex_wreg &
               ((id_use1 & (id_rs1 == ex_dest)) | (id_use2 & (id_rs2 == ex_dest)));

   assign dbg_state = state;

   // Freeze and memory request depend on state and the live ack, so an ack
   // releases the pipe in the same cycle it arrives.
   always_comb begin
      freeze   = 1'b0;
      dmem_req = 1'b0;
      case (state)
         RUN: begin
            dmem_req = mem_op;
            freeze   = mem_op & ~dmem_ack;
         end
         WAIT: begin
            dmem_req = 1'b1;
            freeze   = ~dmem_ack;
         end
         ERR: begin
            freeze = 1'b1;
         end
         default: begin
            freeze = 1'b1;
         end
      endcase
      // Reset presents a quiet, free-running pipe with no memory request.
      if (rst) begin
         dmem_req = 1'b0;
      end
   end

   always_comb begin
      en_if     = 1'b1;
      en_id     = 1'b1;
      en_ex     = 1'b1;
      en_mem    = 1'b1;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      if (rst) begin
         en_if = 1'b1;
      end else if (freeze) begin
         en_if  = 1'b0;
         en_id  = 1'b0;
         en_ex  = 1'b0;
         en_mem = 1'b0;
      end else if (branch_taken) begin
         // Wrong-path instructions in IF/ID and ID are squashed; this also
         // removes any load-use consumer, so no stall is needed.
         flush_id  = 1'b1;
         bubble_ex = 1'b1;
      end else if (lu) begin
         en_if     = 1'b0;
         en_id     = 1'b0;
         bubble_ex = 1'b1;
      end
   end

   assign lu_stall  = lu & ~freeze & ~branch_taken;
   assign stall_evt = freeze | lu_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         case (state)
            RUN: begin
               if (mem_op && !dmem_ack) begin
                  state    <= WAIT;
                  wait_cnt <= '0;
               end
            end
            WAIT: begin
               if (dmem_ack) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1)) begin
                  // This cycle is the MEM_TIMEOUT-th WAIT cycle without ack.
                  state   <= ERR;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WCNT_W'(1);
               end
            end
            ERR: begin
               mem_err <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. The DUT is built with CNT_W = 4 so
// that stall counter saturation is reached in a handful of cycles.

module tb_pipeline_hazard_ctrl;

   localparam int MEM_TIMEOUT = 15;
   localparam int CNT_W       = 4;
   localparam int SAT         = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       id_rs1, id_rs2, ex_dest;
   logic             id_use1, id_use2, ex_rmem, ex_wreg;
   logic             mem_rmem, mem_wmem, branch_taken, dmem_ack;
   logic             en_if, en_id, en_ex, en_mem, bubble_ex, flush_id;
   logic             dmem_req, mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [1:0]       dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
      .ex_dest(ex_dest), .ex_rmem(ex_rmem), .ex_wreg(ex_wreg),
      .mem_rmem(mem_rmem), .mem_wmem(mem_wmem), .branch_taken(branch_taken),
      .dmem_ack(dmem_ack),
      .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .en_mem(en_mem),
      .bubble_ex(bubble_ex), .flush_id(flush_id),
      .dmem_req(dmem_req), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Output bundle: {en_if,en_id,en_ex,en_mem,bubble_ex,flush_id,dmem_req,mem_err}
   function automatic logic [7:0] outv();
      return {en_if, en_id, en_ex, en_mem, bubble_ex, flush_id, dmem_req, mem_err};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      id_rs1 = 4'd0; id_rs2 = 4'd0; id_use1 = 1'b0; id_use2 = 1'b0;
      ex_dest = 4'd0; ex_rmem = 1'b0; ex_wreg = 1'b0;
      mem_rmem = 1'b0; mem_wmem = 1'b0; branch_taken = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic set_lu(input logic [3:0] dest, input logic [3:0] rs1, input logic u1,
                         input logic [3:0] rs2, input logic u2, input logic wreg);
      ex_rmem = 1'b1; ex_wreg = wreg; ex_dest = dest;
      id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
   endtask

   // ---------------- behavioural model + compare ----------------
   // The model tracks whether a memory access is outstanding from an earlier
   // cycle, how many cycles it has gone unanswered after that, whether the
   // timeout error has fired, and the running stall total.
   bit m_busy   = 1'b0;
   int m_waited = 0;
   bit m_err    = 1'b0;
   int m_stall  = 0;

   initial begin
      @(posedge clk);
      forever begin
         logic [7:0] exp_v;
         bit access, frz, hazard;
         @(negedge clk);
         access = m_busy || mem_rmem || mem_wmem;
         hazard = ex_rmem && ex_wreg &&
                  ((id_use1 && id_rs1 == ex_dest) || (id_use2 && id_rs2 == ex_dest));
         frz    = m_err || (access && !dmem_ack);
         if (rst)               exp_v = {6'b111100, 1'b0, m_err};
         else if (frz)          exp_v = {6'b000000, !m_err && access, m_err};
         else if (branch_taken) exp_v = {6'b111111, !m_err && access, m_err};
         else if (hazard)       exp_v = {6'b001110, !m_err && access, m_err};
         else                   exp_v = {6'b111100, !m_err && access, m_err};
         chk("model_outputs", int'(outv()), int'(exp_v));
         chk("model_stall_cnt", int'(stall_cnt), m_stall);
         // advance the model with the inputs the coming edge will sample
         if (rst) begin
            m_busy = 1'b0; m_waited = 0; m_err = 1'b0; m_stall = 0;
         end else begin
            if (frz || (hazard && !branch_taken)) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            if (m_err) begin
               m_err = 1'b1;
            end else if (m_busy) begin
               if (dmem_ack) m_busy = 1'b0;
               else begin
                  m_waited++;
                  if (m_waited == MEM_TIMEOUT) begin
                     m_err = 1'b1; m_busy = 1'b0;
                  end
               end
            end else if ((mem_rmem || mem_wmem) && !dmem_ack) begin
               m_busy = 1'b1; m_waited = 0;
            end
         end
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      clear_in();
      rst = 1'b1;
      mem_rmem = 1'b1;
      tick(); #1;
      chk("rst_outputs", int'(outv()), 8'b1111_0000);
      tick(); rst = 1'b0; mem_rmem = 1'b0; #1;
      chk("reset_stall_cnt", int'(stall_cnt), 0);
      chk("reset_state", int'(dbg_state), 0);

      // load into R5 in EX, ID reads R5 via rs2
      tick(); set_lu(4'd5, 4'd3, 1'b1, 4'd5, 1'b1, 1'b1); #1;
      chk("lu_r5", int'(outv()), 8'b0011_1000);
      tick(); clear_in(); #1;
      chk("lu_one_cycle", int'(outv()), 8'b1111_0000);
      chk("lu_stall_cnt", int'(stall_cnt), 1);
      tick(); set_lu(4'd0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b1); #1;
      chk("lu_r0", int'(outv()), 8'b0011_1000);
      tick(); set_lu(4'd0, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1); #1;
      chk("no_use", int'(outv()), 8'b1111_0000);
      tick(); set_lu(4'd7, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0); #1;
      chk("no_wreg", int'(outv()), 8'b1111_0000);

      // store in MEM, ack after three unanswered cycles
      tick(); clear_in(); rst = 1'b1;
      tick(); rst = 1'b0; mem_wmem = 1'b1; #1;
      chk("store_freeze", int'(outv()), 8'b0000_0010);
      tick();
      tick(); #1;
      chk("store_wait", int'(outv()), 8'b0000_0010);
      tick(); dmem_ack = 1'b1; #1;
      chk("store_ack_cycle", int'(outv()), 8'b1111_0010);
      tick(); clear_in(); #1;
      chk("store_stall_cnt", int'(stall_cnt), 3);
      chk("store_back_run", int'(dbg_state), 0);

      // load acknowledged in the same cycle
      tick(); mem_rmem = 1'b1; dmem_ack = 1'b1; #1;
      chk("load_ack_now", int'(outv()), 8'b1111_0010);
      tick(); clear_in(); #1;
      chk("load_ack_cnt", int'(stall_cnt), 3);
      chk("load_ack_state", int'(dbg_state), 0);

      // branch overrides load-use
      tick(); set_lu(4'd2, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1); branch_taken = 1'b1; #1;
      chk("br_over_lu", int'(outv()), 8'b1111_1100);
      tick(); clear_in(); #1;
      chk("br_no_stall", int'(stall_cnt), 3);

      // freeze overrides branch
      tick(); mem_rmem = 1'b1; branch_taken = 1'b1; #1;
      chk("freeze_over_br", int'(outv()), 8'b0000_0010);
      tick(); branch_taken = 1'b0; dmem_ack = 1'b1; #1;
      chk("wait_ack_release", int'(outv()), 8'b1111_0010);

      // reset in the middle of WAIT, then a stale ack
      tick(); clear_in(); mem_rmem = 1'b1;
      tick(); rst = 1'b1; #1;
      chk("rst_in_wait", int'(outv()), 8'b1111_0000);
      tick(); rst = 1'b0; mem_rmem = 1'b0; dmem_ack = 1'b1; #1;
      chk("stale_ack", int'(outv()), 8'b1111_0000);
      chk("stale_ack_cnt", int'(stall_cnt), 0);
      tick(); clear_in(); #1;
      chk("stale_ack_state", int'(dbg_state), 0);

      // timeout: one RUN cycle plus MEM_TIMEOUT WAIT cycles without ack
      tick(); mem_rmem = 1'b1;
      for (int i = 0; i < MEM_TIMEOUT; i++) tick();
      #1;
      chk("wait_last", int'(outv()), 8'b0000_0010);
      tick(); #1;
      chk("err_entry", int'(outv()), 8'b0000_0001);
      chk("err_state", int'(dbg_state), 2);
      tick(); mem_rmem = 1'b0; dmem_ack = 1'b1; branch_taken = 1'b1; #1;
      chk("err_sticky", int'(outv()), 8'b0000_0001);
      chk("stall_sat_err", int'(stall_cnt), SAT);
      tick(); tick(); #1;
      chk("stall_sat_hold", int'(stall_cnt), SAT);
      tick(); clear_in(); rst = 1'b1; #1;
      chk("rst_in_err", int'(outv()), 8'b1111_0001);
      tick(); rst = 1'b0; #1;
      chk("err_cleared", int'(outv()), 8'b1111_0000);
      chk("err_cleared_cnt", int'(stall_cnt), 0);
      chk("err_cleared_state", int'(dbg_state), 0);

      // saturation through load-use stalls
      for (int i = 0; i < SAT + 4; i++) begin
         tick(); set_lu(4'd6, 4'd6, 1'b1, 4'd1, 1'b0, 1'b1);
      end
      tick(); clear_in(); #1;
      chk("stall_sat_lu", int'(stall_cnt), SAT);

      // mixed traffic, checked by the model only
      for (int i = 0; i < 400; i++) begin
         tick();
         rst          = ($urandom_range(0, 99) < 3);
         id_rs1       = 4'($urandom_range(0, 15));
         id_rs2       = 4'($urandom_range(0, 15));
         ex_dest      = 4'($urandom_range(0, 3));
         id_use1      = 1'($urandom_range(0, 1));
         id_use2      = 1'($urandom_range(0, 1));
         ex_rmem      = 1'($urandom_range(0, 1));
         ex_wreg      = 1'($urandom_range(0, 1));
         mem_rmem     = ($urandom_range(0, 99) < 20);
         mem_wmem     = ($urandom_range(0, 99) < 15);
         branch_taken = ($urandom_range(0, 99) < 15);
         dmem_ack     = ($urandom_range(0, 99) < 30);
         if (id_rs1 > 4'd3) id_rs1 = ex_dest;
      end
      tick(); clear_in();
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
